// File: rtl/wb_ibex_device_bridge_if.sv
// wb_ibex_device_bridge_if: Wishbone slave-port and Ibex device-port signals of the bridge.
interface wb_ibex_device_bridge_if #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   logic                      wb_cyc_i;
   logic                      wb_stb_i;
   logic                      wb_we_i;
   logic [AddressWidth-1:0]   wb_addr_i;
   logic [DataWidth-1:0]      wb_data_i;
   logic [DataWidth/8-1:0]    wb_sel_i;
   logic                      wb_stall_o;
   logic                      wb_ack_o;
   logic [DataWidth-1:0]      wb_data_o;
   logic                      wb_err_o;
   logic                      device_req_o;
   logic                      device_gnt_i;
   logic [AddressWidth-1:0]   device_addr_o;
   logic                      device_we_o;
   logic [DataWidth/8-1:0]    device_be_o;
   logic [DataWidth-1:0]      device_wdata_o;
   logic                      device_rvalid_i;
   logic [DataWidth-1:0]      device_rdata_i;
   logic                      device_err_i;
   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
      input  device_gnt_i, device_rvalid_i, device_rdata_i, device_err_i,
      output wb_stall_o, wb_ack_o, wb_data_o, wb_err_o,
      output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );
   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
      output device_gnt_i, device_rvalid_i, device_rdata_i, device_err_i,
      input  wb_stall_o, wb_ack_o, wb_data_o, wb_err_o,
      input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
   );
endinterface

// File: rtl/wb_ibex_device_bridge.sv
// wb_ibex_device_bridge: pipelined Wishbone slave to Ibex req/gnt/rvalid device bridge.
// Define WB_DEV_BRIDGE_TIMEOUT_EN to add the response timeout.
module wb_ibex_device_bridge #(
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2,
   parameter int TimeoutCycles  = 255
) (
   input logic                    clk_i,
   input logic                    reset_i,
   wb_ibex_device_bridge_if.slave bus
);
   localparam int BeWidth = DataWidth / 8;
   typedef enum logic {IDLE, REQ} state_e;
   state_e                  state_q, state_d;
   logic [AddressWidth-1:0] addr_q, addr_d;
   logic                    we_q, we_d;
   logic [BeWidth-1:0]      be_q, be_d;
   logic [DataWidth-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]              out_q, out_d, disc_q, disc_d, out_n, disc_n;
   logic                    orphan_q, orphan_d, ack_q, ack_d, err_q, err_d;
   logic                    req, stall, accept, gnt_ev, orphan_now, gnt_out, gnt_disc;
   logic                    resp_ev, to_out, to_disc, flush, to_ev;

   if (MaxOutstanding < 1 || MaxOutstanding > 7 || TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_param_check
      $error("wb_ibex_device_bridge: parameter out of range");
   end

`ifdef WB_DEV_BRIDGE_TIMEOUT_EN
   logic [7:0] timer_q, timer_d;
   always_comb begin
      to_ev   = (out_q != 4'd0) & ~bus.device_rvalid_i & (timer_q == 8'(TimeoutCycles - 1));
      timer_d = (bus.device_rvalid_i | (out_q == 4'd0) | to_ev) ? 8'd0 : timer_q + 8'd1;
   end
   always_ff @(posedge clk_i) timer_q <= reset_i ? 8'd0 : timer_d;
`else
   assign to_ev = 1'b0;
`endif

   // A request still pending when cyc drops is "orphaned": its grant feeds discard, not outstanding.
   always_comb begin
      req        = state_q == REQ;
      gnt_ev     = req & bus.device_gnt_i;
      orphan_now = orphan_q | ~bus.wb_cyc_i;
      stall      = ~bus.wb_cyc_i | (req & (~bus.device_gnt_i | orphan_q)) | (disc_q != 4'd0)
                 | (out_q + {3'b0, req} >= 4'(MaxOutstanding));
      accept     = bus.wb_cyc_i & bus.wb_stb_i & ~stall;
      gnt_out    = gnt_ev & ~orphan_now;
      gnt_disc   = gnt_ev & orphan_now;
      resp_ev    = bus.device_rvalid_i & ((out_q != 4'd0) | (disc_q != 4'd0));
      to_disc    = resp_ev & (disc_q != 4'd0);
      to_out     = resp_ev & (disc_q == 4'd0);
      out_n      = out_q + {3'b0, gnt_out} - {3'b0, to_out};
      disc_n     = disc_q + {3'b0, gnt_disc} - {3'b0, to_disc};
      flush      = ~bus.wb_cyc_i | to_ev;
      out_d      = flush ? 4'd0 : out_n;
      disc_d     = flush ? disc_n + out_n : disc_n;
      state_d    = accept ? REQ : gnt_ev ? IDLE : state_q;
      orphan_d   = (accept | gnt_ev) ? 1'b0 : orphan_q | (req & ~bus.wb_cyc_i);
      addr_d     = accept ? bus.wb_addr_i : addr_q;
      we_d       = accept ? bus.wb_we_i : we_q;
      be_d       = accept ? bus.wb_sel_i : be_q;
      wdata_d    = accept ? bus.wb_data_i : wdata_q;
      ack_d      = to_out & bus.wb_cyc_i & ~bus.device_err_i;
      err_d      = (to_out & bus.wb_cyc_i & bus.device_err_i) | to_ev;
      rdata_d    = bus.device_rvalid_i ? bus.device_rdata_i : rdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         out_q    <= 4'd0;
         disc_q   <= 4'd0;
         orphan_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
         orphan_q <= orphan_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign bus.wb_stall_o     = stall;
   assign bus.wb_ack_o       = ack_q;
   assign bus.wb_err_o       = err_q;
   assign bus.wb_data_o      = rdata_q;
   assign bus.device_req_o   = state_q == REQ;
   assign bus.device_addr_o  = addr_q;
   assign bus.device_we_o    = we_q;
   assign bus.device_be_o    = be_q;
   assign bus.device_wdata_o = wdata_q;
endmodule

// File: tb/tb_wb_ibex_device_bridge.sv
// tb_wb_ibex_device_bridge: directed and randomized self-checking bench for wb_ibex_device_bridge.
module tb_wb_ibex_device_bridge;
   localparam int DW = 32, AW = 32, SW = DW / 8, MO = 2, TO = 16, NRND = 200;
   typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;} req_t;
   typedef struct {logic err; logic [DW-1:0] d; int due;} rsp_t;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;

   wb_ibex_device_bridge_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();
   wb_ibex_device_bridge #(.DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO), .TimeoutCycles(TO))
      dut (.clk_i(clk), .reset_i(rst), .bus(bus.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_addr_i = '0; bus.wb_data_i = '0; bus.wb_sel_i = '0;
      bus.device_gnt_i = 1'b0; bus.device_rvalid_i = 1'b0; bus.device_rdata_i = '0; bus.device_err_i = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.device_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.device_req_o); end
      n_cmp++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin n_bad++; $display("FAIL reset_ack_err: got %b want 00", {bus.wb_ack_o, bus.wb_err_o}); end
      n_cmp++; if (bus.wb_data_o !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.wb_data_o); end
      n_cmp++; if ({bus.device_addr_o, bus.device_we_o, bus.device_be_o, bus.device_wdata_o} !== '0) begin n_bad++; $display("FAIL reset_hold: addr %h we %b be %b wdata %h want all 0", bus.device_addr_o, bus.device_we_o, bus.device_be_o, bus.device_wdata_o); end
      n_cmp++; if (bus.wb_stall_o !== 1'b1) begin n_bad++; $display("FAIL reset_stall_nocyc: got %b want 1", bus.wb_stall_o); end
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_addr_i = 32'hCAFE0000; bus.wb_sel_i = '1; bus.wb_data_i = 32'h55AA55AA;
      #1;
      n_cmp++; if (bus.wb_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_stall: got %b want 0", bus.wb_stall_o); end
      tick();
      bus.wb_stb_i = 1'b0;
      n_cmp++; if (bus.device_req_o !== 1'b1) begin n_bad++; $display("FAIL reset_pre_req: got %b want 1", bus.device_req_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.device_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_mid_req: got %b want 0", bus.device_req_o); end
      n_cmp++; if (bus.device_addr_o !== '0) begin n_bad++; $display("FAIL reset_mid_addr: got %h want 0", bus.device_addr_o); end
      #1;
      n_cmp++; if (bus.wb_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_mid_stall: got %b want 0", bus.wb_stall_o); end
   endtask

   task automatic test_read();
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_addr_i = 32'h80001000; bus.wb_sel_i = '1;
      tick();
      bus.wb_stb_i = 1'b0; bus.device_gnt_i = 1'b1;
      n_cmp++; if ({bus.device_req_o, bus.device_we_o, bus.device_addr_o} !== {2'b10, 32'h80001000}) begin n_bad++; $display("FAIL read_req: req %b we %b addr %h want 1 0 80001000", bus.device_req_o, bus.device_we_o, bus.device_addr_o); end
      tick();
      bus.device_gnt_i = 1'b0;
      n_cmp++; if (bus.device_req_o !== 1'b0) begin n_bad++; $display("FAIL read_req_drop: got %b want 0", bus.device_req_o); end
      tick();
      bus.device_rvalid_i = 1'b1; bus.device_rdata_i = 32'hDEADBEEF;
      n_cmp++; if (bus.wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL read_early_ack: got %b want 0", bus.wb_ack_o); end
      tick();
      bus.device_rvalid_i = 1'b0; bus.device_rdata_i = 32'h0;
      n_cmp++; if ({bus.wb_ack_o, bus.wb_err_o, bus.wb_data_o} !== {2'b10, 32'hDEADBEEF}) begin n_bad++; $display("FAIL read_ack: ack %b err %b data %h want 1 0 deadbeef", bus.wb_ack_o, bus.wb_err_o, bus.wb_data_o); end
      tick();
      n_cmp++; if ({bus.wb_ack_o, bus.wb_data_o} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL read_ack_once: ack %b data %h want 0 deadbeef", bus.wb_ack_o, bus.wb_data_o); end
   endtask

   task automatic test_write_wait();
      logic [AW-1:0] a;
      a = $urandom() & 32'hFFFF_FFFC;
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_addr_i = a;
      bus.wb_sel_i = 4'b0011; bus.wb_data_i = 32'h12345678;
      tick();
      bus.wb_stb_i = 1'b0; bus.wb_addr_i = ~a; bus.wb_data_i = '0; bus.wb_sel_i = '0;
      for (int i = 0; i < 4; i++) begin
         bus.device_gnt_i = (i == 3);
         #1;
         n_cmp++; if ({bus.device_req_o, bus.device_we_o, bus.device_addr_o, bus.device_be_o, bus.device_wdata_o} !== {2'b11, a, 4'b0011, 32'h12345678}) begin n_bad++; $display("FAIL write_hold[%0d]: req %b we %b addr %h be %b wdata %h want 1 1 %h 0011 12345678", i, bus.device_req_o, bus.device_we_o, bus.device_addr_o, bus.device_be_o, bus.device_wdata_o, a); end
         n_cmp++; if (bus.wb_stall_o !== (i != 3)) begin n_bad++; $display("FAIL write_stall[%0d]: got %b want %b", i, bus.wb_stall_o, i != 3); end
         tick();
      end
      bus.device_gnt_i = 1'b0; bus.device_rvalid_i = 1'b1; bus.device_rdata_i = $urandom();
      n_cmp++; if (bus.device_req_o !== 1'b0) begin n_bad++; $display("FAIL write_req_drop: got %b want 0", bus.device_req_o); end
      tick();
      bus.device_rvalid_i = 1'b0;
      n_cmp++; if (bus.wb_ack_o !== 1'b1) begin n_bad++; $display("FAIL write_ack: got %b want 1", bus.wb_ack_o); end
      tick();
      n_cmp++; if (bus.wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL write_ack_once: got %b want 0", bus.wb_ack_o); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_q[$], dat_q[$];
      int due_q[$];
      int sent = 0, acks = 0, first_rv = -1, third_acc = -1;
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.device_gnt_i = 1'b1;
      for (int c = 0; c < 60 && acks < 3; c++) begin
         if (bus.wb_ack_o) begin
            n_cmp++; if (exp_q.size() == 0 || bus.wb_data_o !== exp_q[0]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", acks, bus.wb_data_o, exp_q.size() ? exp_q[0] : 'x); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            acks++;
         end
         if (bus.device_req_o) begin due_q.push_back(c + 4); dat_q.push_back($urandom()); end
         bus.device_rvalid_i = due_q.size() != 0 && due_q[0] <= c;
         if (bus.device_rvalid_i) begin
            void'(due_q.pop_front());
            bus.device_rdata_i = dat_q.pop_front();
            exp_q.push_back(bus.device_rdata_i);
            if (first_rv < 0) first_rv = c;
         end
         bus.wb_stb_i = sent < 3; bus.wb_addr_i = 32'h1000 + 32'(4 * sent);
         #1;
         if (bus.wb_stb_i && !bus.wb_stall_o) begin sent++; if (sent == 3) third_acc = c; end
         tick();
      end
      quiet(); bus.wb_cyc_i = 1'b1;
      n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL b2b_acks: got %0d want 3", acks); end
      n_cmp++; if (third_acc <= first_rv) begin n_bad++; $display("FAIL b2b_third_stall: third accepted at %0d, first rvalid at %0d, want later", third_acc, first_rv); end
   endtask

   task automatic test_error();
      logic [DW-1:0] d;
      d = $urandom();
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h40;
      tick();
      bus.wb_stb_i = 1'b0; bus.device_gnt_i = 1'b1;
      tick();
      bus.device_gnt_i = 1'b0; bus.device_rvalid_i = 1'b1; bus.device_err_i = 1'b1; bus.device_rdata_i = d;
      tick();
      bus.device_rvalid_i = 1'b0; bus.device_err_i = 1'b0;
      n_cmp++; if ({bus.wb_err_o, bus.wb_ack_o} !== 2'b10) begin n_bad++; $display("FAIL err_resp: err %b ack %b want 1 0", bus.wb_err_o, bus.wb_ack_o); end
      tick();
      n_cmp++; if ({bus.wb_err_o, bus.wb_ack_o} !== 2'b00) begin n_bad++; $display("FAIL err_once: err %b ack %b want 0 0", bus.wb_err_o, bus.wb_ack_o); end
   endtask

   task automatic test_cyc_drop();
      logic [DW-1:0] d;
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.device_gnt_i = 1'b1; bus.wb_addr_i = 32'h100;
      tick();
      bus.wb_addr_i = 32'h104;
      #1;
      n_cmp++; if (bus.wb_stall_o !== 1'b0) begin n_bad++; $display("FAIL drop_second_accept: stall %b want 0", bus.wb_stall_o); end
      tick();
      bus.wb_stb_i = 1'b0;
      tick();
      bus.wb_cyc_i = 1'b0; bus.device_gnt_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.device_rvalid_i = (i == 1 || i == 2); bus.device_err_i = (i == 2); bus.device_rdata_i = $urandom();
         tick();
         n_cmp++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin n_bad++; $display("FAIL drop_swallow[%0d]: ack %b err %b want 0 0", i, bus.wb_ack_o, bus.wb_err_o); end
      end
      d = $urandom();
      bus.device_rvalid_i = 1'b0; bus.device_err_i = 1'b0;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h200;
      #1;
      n_cmp++; if (bus.wb_stall_o !== 1'b0) begin n_bad++; $display("FAIL drop_reaccept: stall %b want 0", bus.wb_stall_o); end
      tick();
      bus.wb_stb_i = 1'b0; bus.device_gnt_i = 1'b1;
      tick();
      bus.device_gnt_i = 1'b0; bus.device_rvalid_i = 1'b1; bus.device_rdata_i = d;
      tick();
      bus.device_rvalid_i = 1'b0;
      n_cmp++; if ({bus.wb_ack_o, bus.wb_data_o} !== {1'b1, d}) begin n_bad++; $display("FAIL drop_next_ack: ack %b data %h want 1 %h", bus.wb_ack_o, bus.wb_data_o, d); end
   endtask

`ifdef WB_DEV_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      int seen = -1, errs = 0;
      do_reset();
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h300;
      tick();
      bus.wb_stb_i = 1'b0; bus.device_gnt_i = 1'b1;
      tick();
      bus.device_gnt_i = 1'b0;
      for (int k = 1; k <= TO + 4; k++) begin
         tick();
         if (bus.wb_err_o) begin errs++; if (seen < 0) seen = k; end
      end
      n_cmp++; if (seen != TO) begin n_bad++; $display("FAIL timeout_cycle: err at %0d want %0d", seen, TO); end
      n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL timeout_pulse: %0d err cycles want 1", errs); end
      bus.device_rvalid_i = 1'b1; bus.device_rdata_i = $urandom();
      tick();
      bus.device_rvalid_i = 1'b0;
      tick();
      n_cmp++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin n_bad++; $display("FAIL timeout_late: ack %b err %b want 0 0", bus.wb_ack_o, bus.wb_err_o); end
      bus.wb_stb_i = 1'b1;
      #1;
      n_cmp++; if (bus.wb_stall_o !== 1'b0) begin n_bad++; $display("FAIL timeout_reaccept: stall %b want 0", bus.wb_stall_o); end
      tick();
      quiet();
   endtask
`endif

   task automatic test_random();
      req_t acc_q[$], cur, r;
      rsp_t dev_q[$], exp_q[$], p;
      int issued = 0, done = 0, last_due = 0;
      bit have = 0;
      do_reset();
      bus.wb_cyc_i = 1'b1;
      for (int c = 0; c < 5000 && done < NRND; c++) begin
         if (bus.wb_ack_o || bus.wb_err_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_spurious: ack %b err %b with nothing due", bus.wb_ack_o, bus.wb_err_o); end
            else begin
               p = exp_q.pop_front();
               if ({bus.wb_ack_o, bus.wb_err_o, bus.wb_data_o} !== {~p.err, p.err, p.d}) begin n_bad++; $display("FAIL rnd_resp[%0d]: ack %b err %b data %h want %b %b %h", done, bus.wb_ack_o, bus.wb_err_o, bus.wb_data_o, ~p.err, p.err, p.d); end
               done++;
            end
         end
         bus.device_gnt_i = $urandom_range(0, 3) != 0;
         if (bus.device_req_o && bus.device_gnt_i) begin
            n_cmp++;
            if (acc_q.size() == 0) begin n_bad++; $display("FAIL rnd_req_spurious: req granted with nothing accepted"); end
            else begin
               r = acc_q.pop_front();
               if ({bus.device_we_o, bus.device_addr_o, bus.device_be_o, bus.device_wdata_o} !== {r.we, r.a, r.s, r.d}) begin n_bad++; $display("FAIL rnd_dev_req: we %b addr %h be %b wdata %h want %b %h %b %h", bus.device_we_o, bus.device_addr_o, bus.device_be_o, bus.device_wdata_o, r.we, r.a, r.s, r.d); end
               p.err = $urandom_range(0, 7) == 0; p.d = $urandom();
               p.due = c + 1 + int'($urandom_range(0, 4));
               if (p.due <= last_due) p.due = last_due + 1;
               last_due = p.due;
               dev_q.push_back(p);
            end
         end
         bus.device_rvalid_i = dev_q.size() != 0 && dev_q[0].due <= c;
         if (bus.device_rvalid_i) begin
            p = dev_q.pop_front();
            bus.device_rdata_i = p.d; bus.device_err_i = p.err;
            exp_q.push_back(p);
         end else begin
            bus.device_rdata_i = $urandom(); bus.device_err_i = 1'($urandom_range(0, 1));
         end
         if (!have && issued < NRND && $urandom_range(0, 1) == 1) begin
            cur.we = 1'($urandom_range(0, 1)); cur.a = $urandom(); cur.d = $urandom(); cur.s = 4'($urandom());
            have = 1;
         end
         bus.wb_stb_i = have; bus.wb_we_i = cur.we; bus.wb_addr_i = cur.a; bus.wb_data_i = cur.d; bus.wb_sel_i = cur.s;
         #1;
         if (have && !bus.wb_stall_o) begin acc_q.push_back(cur); have = 0; issued++; end
         n_cmp++; if (acc_q.size() > 1 || acc_q.size() + dev_q.size() > MO) begin n_bad++; $display("FAIL rnd_inflight: pending %0d granted %0d limit %0d", acc_q.size(), dev_q.size(), MO); end
         tick();
      end
      quiet();
      n_cmp++; if (issued != NRND || done != NRND) begin n_bad++; $display("FAIL rnd_count: issued %0d answered %0d want %0d", issued, done, NRND); end
   endtask

   initial begin
      rst = 1'b1;
      quiet();
      test_reset();
      test_read();
      test_write_wait();
      test_back_to_back();
      test_error();
      test_cyc_drop();
`ifdef WB_DEV_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
